// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// bcd_pkg : shared state encoding and digit-correction constants for the
//           binary-to-BCD converter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_ADD_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD_VAL    = 4'd3;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
//------------------------------------------------------------------------------
// bcd_add3 : one-digit add-3 correction (in >= 5 ? in + 3 : in), combinational.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= BCD_ADD_THRESH) ? (i_nib + BCD_ADD_VAL) : i_nib;

endmodule

`default_nettype wire

// File: rtl/bin_para_bcd.sv
//------------------------------------------------------------------------------
// bin_para_bcd : sequential double-dabble binary-to-BCD converter with a
//                start/ready/done_tick handshake; W shift cycles per conversion.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin_para_bcd
  import bcd_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                ready,
  output logic                done_tick,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int AW = 4 * DIGITS;

  generate
    if ((10 ** DIGITS) <= ((2 ** W) - 1)) begin : g_digits_check
      $error("bin_para_bcd: DIGITS too small to hold the largest W-bit value");
    end
  endgenerate

  bcd_state_t      state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   bcd_q, bcd_d;
  logic            ready_q, ready_d;
  logic            done_tick_q, done_tick_d;
  logic [AW-1:0]   acc_adj;
  logic            unused_msb;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
        .i_nib (acc_q[4*g +: 4]),
        .o_nib (acc_adj[4*g +: 4])
      );
    end
  endgenerate

  // The bit shifted out of the top digit is always 0 given the DIGITS bound.
  assign unused_msb = acc_adj[AW-1];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    count_d   = count_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          acc_d   = '0;
          count_d = CW'(W);
          state_d = OP;
        end
      end
      OP: begin
        acc_d   = {acc_adj[AW-2:0], shift_q[W-1]};
        shift_d = {shift_q[W-2:0], 1'b0};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = {acc_adj[AW-2:0], shift_q[W-1]};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == IDLE);
    done_tick_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      bcd_q       <= '0;
      ready_q     <= 1'b1;
      done_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      bcd_q       <= bcd_d;
      ready_q     <= ready_d;
      done_tick_q <= done_tick_d;
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_tick_q;
  assign bcd       = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_para_bcd.sv
//------------------------------------------------------------------------------
// tb_bin_para_bcd : directed self-checking bench for bin_para_bcd (W=16, 5 digits).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bin_para_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        ready;
  logic        done_tick;
  logic [19:0] bcd;

  int errors = 0;
  int checks = 0;

  bin_para_bcd #(.W(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for idle, requests one conversion, and counts edges from the
  // request until done_tick (bounded at 40 edges).
  task automatic convert(input logic [15:0] v, output int lat,
                         output logic [19:0] res, output int rdy_hi);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bin = v; start = 1'b1;
    lat = 0; rdy_hi = 0; res = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done_tick) begin
        res = bcd;
        break;
      end
      if (ready) rdy_hi++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_tick); end
    checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd got=%h exp=00000", bcd); end
  endtask

  task automatic test_basic();
    int lat, rh;
    logic [19:0] res;
    convert(16'd20, lat, res, rh);
    checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (res !== 20'h00020) begin errors++; $display("FAIL basic_bcd got=%h exp=00020", res); end
    checks++; if (rh !== 0) begin errors++; $display("FAIL basic_ready_busy got=%0d cycles ready exp=0", rh); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got=%b exp=1", ready); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL basic_done_single got=%b exp=0", done_tick); end
    checks++; if (bcd !== 20'h00020) begin errors++; $display("FAIL basic_bcd_hold got=%h exp=00020", bcd); end
  endtask

  task automatic test_corners();
    logic [15:0] vals [4];
    logic [19:0] exps [4];
    int lat, rh;
    logic [19:0] res;
    vals[0] = 16'd0;     exps[0] = 20'h00000;
    vals[1] = 16'd9;     exps[1] = 20'h00009;
    vals[2] = 16'd10;    exps[2] = 20'h00010;
    vals[3] = 16'd65535; exps[3] = 20'h65535;
    for (int k = 0; k < 4; k++) begin
      convert(vals[k], lat, res, rh);
      checks++;
      if (res !== exps[k]) begin
        errors++; $display("FAIL corner_bcd bin=%0d got=%h exp=%h", vals[k], res, exps[k]);
      end
      checks++;
      if (lat !== 17) begin
        errors++; $display("FAIL corner_latency bin=%0d got=%0d exp=17", vals[k], lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, ndone, tdone;
    logic [19:0] res;
    int guard;
    guard = 0; ndone = 0; tdone = 0; cyc = 0; res = '0;
    @(negedge clk);
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    bin = 16'd350; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 4) begin bin = 16'd17; start = 1'b1; end
      if (cyc == 5) start = 1'b0;
      if (done_tick) begin ndone++; res = bcd; tdone = cyc; end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (res !== 20'h00350) begin errors++; $display("FAIL ignore_bcd got=%h exp=00350", res); end
    checks++; if (tdone !== 17) begin errors++; $display("FAIL ignore_latency got=%0d exp=17", tdone); end
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    int t [2];
    logic [19:0] v [2];
    int guard;
    guard = 0; cyc = 0; n = 0;
    t[0] = 0; t[1] = 0; v[0] = '0; v[1] = '0;
    @(negedge clk);
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    bin = 16'd1234; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) bin = 16'd4321;
      if (done_tick) begin
        t[n] = cyc; v[n] = bcd; n++;
        if (n == 2) break;
      end
    end
    start = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", n); end
    checks++; if (t[0] !== 17) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=17", t[0]); end
    checks++; if ((t[1] - t[0]) !== 18) begin errors++; $display("FAIL b2b_spacing got=%0d exp=18", t[1] - t[0]); end
    checks++; if (v[0] !== 20'h01234) begin errors++; $display("FAIL b2b_first_bcd got=%h exp=01234", v[0]); end
    checks++; if (v[1] !== 20'h04321) begin errors++; $display("FAIL b2b_second_bcd got=%h exp=04321", v[1]); end
  endtask

  task automatic test_abort();
    int nd, lat, rh;
    logic [19:0] res;
    int guard;
    guard = 0; nd = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    bin = 16'd400; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", ready); end
    checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL abort_bcd got=%h exp=00000", bcd); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done_tick); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done_tick) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    convert(16'd20, lat, res, rh);
    checks++; if (res !== 20'h00020) begin errors++; $display("FAIL abort_recover_bcd got=%h exp=00020", res); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL abort_recover_latency got=%0d exp=17", lat); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
